// File: rtl/aes_pipeline_stage2.sv
// AES-GCM stage 2: builds IV||inc32 counter blocks, J0, AAD stream and the
// closing length block, and checks the stage-1 phase ordering of each instance.
module aes_pipeline_stage2 #(
  parameter int unsigned CTR_BASE      = 2,
  parameter int unsigned INVALID_COUNT = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] i_counter,
  input  logic [2:0]   i_phase,
  input  logic [127:0] i_plain_text,
  input  logic [127:0] i_aad,
  input  logic [95:0]  i_iv,
  input  logic [127:0] i_instance_size,
  input  logic         i_new_instance,
  input  logic         i_pt_instance,
  output logic [127:0] o_counter_block,
  output logic [127:0] o_text_block,
  output logic         o_aes_valid,
  output logic         o_first_text,
  output logic         o_last_text,
  output logic [127:0] o_ghash_data,
  output logic         o_ghash_valid,
  output logic [127:0] o_j0_block,
  output logic         o_j0_valid,
  output logic [127:0] o_len_block,
  output logic         o_len_valid,
  output logic         o_pt_instance,
  output logic         o_busy,
  output logic         o_err
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned IV_W  = 96;
  localparam int unsigned CTR_W = 32;
  localparam int unsigned LEN_W = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AAD  = 2'd1;
  localparam logic [1:0] ST_TEXT = 2'd2;
  localparam logic [1:0] ST_LEN  = 2'd3;

  localparam logic [2:0] PH_FIRST = 3'b000;
  localparam logic [2:0] PH_MID   = 3'b001;
  localparam logic [2:0] PH_AAD   = 3'b010;
  localparam logic [2:0] PH_LAST  = 3'b011;
  localparam logic [2:0] PH_ONLY  = 3'b111;
  localparam logic [2:0] PH_INV   = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [LEN_W-1:0] aad_bits_q, aad_bits_d;
  logic [LEN_W-1:0] pt_bits_q, pt_bits_d;
  logic [CTR_W-1:0] aad_blocks_q, aad_blocks_d;

  logic [BLK_W-1:0] counter_block_d, text_block_d, ghash_data_d, j0_block_d, len_block_d;
  logic             aes_valid_d, first_text_d, last_text_d, ghash_valid_d;
  logic             j0_valid_d, len_valid_d, err_d;

  logic [2:0]       phase_eff;
  logic [LEN_W-1:0] size_aad, size_pt;
  logic             start_ok, start_has_aad;
  logic [CTR_W-1:0] ctr_value;
  logic             text_hit;

  // The idle sentinel counter overrides whatever phase stage 1 reports.
  assign phase_eff     = (i_counter == BLK_W'(INVALID_COUNT)) ? PH_INV : i_phase;
  assign size_aad      = i_instance_size[127:64];
  assign size_pt       = i_instance_size[63:0];
  assign start_ok      = (size_pt != '0) && (size_aad[6:0] == 7'd0) && (size_pt[6:0] == 7'd0);
  assign start_has_aad = (size_aad[LEN_W-1:7] != '0);
  assign ctr_value     = CTR_W'(i_counter[CTR_W-1:0] - aad_blocks_q + CTR_W'(CTR_BASE));

  // Sequencer state and latched instance fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      iv_q         <= '0;
      aad_bits_q   <= '0;
      pt_bits_q    <= '0;
      aad_blocks_q <= '0;
    end else begin
      state_q      <= state_d;
      iv_q         <= iv_d;
      aad_bits_q   <= aad_bits_d;
      pt_bits_q    <= pt_bits_d;
      aad_blocks_q <= aad_blocks_d;
    end
  end

  // Next state and next output values; data words hold unless their strobe fires.
  always_comb begin
    state_d         = state_q;
    iv_d            = iv_q;
    aad_bits_d      = aad_bits_q;
    pt_bits_d       = pt_bits_q;
    aad_blocks_d    = aad_blocks_q;
    counter_block_d = o_counter_block;
    text_block_d    = o_text_block;
    ghash_data_d    = o_ghash_data;
    j0_block_d      = o_j0_block;
    len_block_d     = o_len_block;
    aes_valid_d     = 1'b0;
    first_text_d    = 1'b0;
    last_text_d     = 1'b0;
    ghash_valid_d   = 1'b0;
    j0_valid_d      = 1'b0;
    len_valid_d     = 1'b0;
    err_d           = 1'b0;
    text_hit        = 1'b0;

    if (i_new_instance) begin
      // A start while busy aborts the running instance.
      err_d   = (state_q != ST_IDLE) || !start_ok;
      state_d = ST_IDLE;
      if (start_ok) begin
        iv_d         = i_iv;
        aad_bits_d   = size_aad;
        pt_bits_d    = size_pt;
        aad_blocks_d = size_aad[CTR_W+6:7];
        j0_valid_d   = 1'b1;
        j0_block_d   = {i_iv, CTR_W'(1)};
        state_d      = start_has_aad ? ST_AAD : ST_TEXT;
      end
    end else begin
      case (state_q)
        ST_AAD: begin
          case (phase_eff)
            PH_AAD: begin
              ghash_valid_d = 1'b1;
              ghash_data_d  = i_aad;
            end
            PH_FIRST, PH_ONLY: text_hit = 1'b1;
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_TEXT: begin
          case (phase_eff)
            PH_FIRST, PH_MID, PH_LAST, PH_ONLY: text_hit = 1'b1;
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_LEN: begin
          len_valid_d = 1'b1;
          len_block_d = {aad_bits_q, pt_bits_q};
          state_d     = ST_IDLE;
        end
        default: ;
      endcase

      if (text_hit) begin
        aes_valid_d     = 1'b1;
        text_block_d    = i_plain_text;
        counter_block_d = {iv_q, ctr_value};
        first_text_d    = (phase_eff == PH_FIRST) || (phase_eff == PH_ONLY);
        last_text_d     = (phase_eff == PH_LAST) || (phase_eff == PH_ONLY);
        state_d         = last_text_d ? ST_LEN : ST_TEXT;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_counter_block <= '0;
      o_text_block    <= '0;
      o_aes_valid     <= 1'b0;
      o_first_text    <= 1'b0;
      o_last_text     <= 1'b0;
      o_ghash_data    <= '0;
      o_ghash_valid   <= 1'b0;
      o_j0_block      <= '0;
      o_j0_valid      <= 1'b0;
      o_len_block     <= '0;
      o_len_valid     <= 1'b0;
      o_pt_instance   <= 1'b0;
      o_busy          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_counter_block <= counter_block_d;
      o_text_block    <= text_block_d;
      o_aes_valid     <= aes_valid_d;
      o_first_text    <= first_text_d;
      o_last_text     <= last_text_d;
      o_ghash_data    <= ghash_data_d;
      o_ghash_valid   <= ghash_valid_d;
      o_j0_block      <= j0_block_d;
      o_j0_valid      <= j0_valid_d;
      o_len_block     <= len_block_d;
      o_len_valid     <= len_valid_d;
      o_pt_instance   <= i_pt_instance;
      o_busy          <= (state_d != ST_IDLE);
      o_err           <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_pipeline_stage2.sv
// Directed bench for aes_pipeline_stage2 with hand-computed expected blocks.
module tb_aes_pipeline_stage2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] i_counter;
  logic [2:0]   i_phase;
  logic [127:0] i_plain_text;
  logic [127:0] i_aad;
  logic [95:0]  i_iv;
  logic [127:0] i_instance_size;
  logic         i_new_instance;
  logic         i_pt_instance;
  logic [127:0] o_counter_block, o_text_block, o_ghash_data, o_j0_block, o_len_block;
  logic         o_aes_valid, o_first_text, o_last_text, o_ghash_valid, o_j0_valid;
  logic         o_len_valid, o_pt_instance, o_busy, o_err;

  int total = 0;
  int bad   = 0;

  localparam logic [95:0] IV1 = 96'hCAFEBABE_FACEDBAD_DECAF888;
  localparam logic [95:0] IV2 = 96'h01234567_89ABCDEF_0F1E2D3C;
  localparam logic [95:0] IV3 = 96'h11111111_22222222_33333333;
  localparam logic [95:0] IV4 = 96'hA5A5A5A5_5A5A5A5A_C3C3C3C3;
  localparam logic [95:0] IV5 = 96'hDEADBEEF_00000000_FFFFFFFF;

  aes_pipeline_stage2 dut (
    .clk(clk), .rst_n(rst_n), .i_counter(i_counter), .i_phase(i_phase),
    .i_plain_text(i_plain_text), .i_aad(i_aad), .i_iv(i_iv),
    .i_instance_size(i_instance_size), .i_new_instance(i_new_instance),
    .i_pt_instance(i_pt_instance), .o_counter_block(o_counter_block),
    .o_text_block(o_text_block), .o_aes_valid(o_aes_valid),
    .o_first_text(o_first_text), .o_last_text(o_last_text),
    .o_ghash_data(o_ghash_data), .o_ghash_valid(o_ghash_valid),
    .o_j0_block(o_j0_block), .o_j0_valid(o_j0_valid), .o_len_block(o_len_block),
    .o_len_valid(o_len_valid), .o_pt_instance(o_pt_instance), .o_busy(o_busy),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  // {aes, ghash, j0, len, err, busy, first, last}
  function automatic logic [7:0] strobes();
    return {o_aes_valid, o_ghash_valid, o_j0_valid, o_len_valid,
            o_err, o_busy, o_first_text, o_last_text};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nw, input logic [2:0] ph, input logic [127:0] ctr);
    i_new_instance = nw;
    i_phase        = ph;
    i_counter      = ctr;
  endtask

  task automatic start(input logic [95:0] iv, input logic [63:0] aad_bits, input logic [63:0] pt_bits);
    i_iv            = iv;
    i_instance_size = {aad_bits, pt_bits};
    drive(1'b1, 3'b100, 128'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL reset_strobes got=%b exp=%b", strobes(), 8'h00); end
    total++;
    if ((|{o_counter_block, o_text_block, o_ghash_data, o_j0_block, o_len_block, o_pt_instance}) !== 1'b0) begin
      bad++; $display("FAIL reset_data got=nonzero exp=0");
    end
    rst_n = 1'b1;
    i_pt_instance = 1'b1;
    tick();
    total++;
    if (o_pt_instance !== 1'b1) begin bad++; $display("FAIL pt_instance_hi got=%b exp=1", o_pt_instance); end
    i_pt_instance = 1'b0;
    tick();
    total++;
    if (o_pt_instance !== 1'b0) begin bad++; $display("FAIL pt_instance_lo got=%b exp=0", o_pt_instance); end
  endtask

  task automatic test_basic();
    start(IV1, 64'h100, 64'h180);
    tick();
    total++;
    if (strobes() !== 8'b0010_0100) begin bad++; $display("FAIL basic_j0_strobes got=%b exp=%b", strobes(), 8'b0010_0100); end
    total++;
    if (o_j0_block !== {IV1, 32'h1}) begin bad++; $display("FAIL basic_j0 got=%h exp=%h", o_j0_block, {IV1, 32'h1}); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 3'b010, 128'(k));
      i_aad = {4{32'hAAD0_0000 + 32'(k)}};
      tick();
      total++;
      if (strobes() !== 8'b0100_0100) begin bad++; $display("FAIL basic_aad%0d_strobes got=%b exp=%b", k, strobes(), 8'b0100_0100); end
      total++;
      if (o_ghash_data !== {4{32'hAAD0_0000 + 32'(k)}}) begin bad++; $display("FAIL basic_aad%0d got=%h", k, o_ghash_data); end
    end
    for (int k = 2; k < 5; k++) begin
      logic [2:0] ph;
      logic [7:0] exp_s;
      ph    = (k == 2) ? 3'b000 : (k == 3) ? 3'b001 : 3'b011;
      exp_s = (k == 2) ? 8'b1000_0110 : (k == 3) ? 8'b1000_0100 : 8'b1000_0101;
      drive(1'b0, ph, 128'(k));
      i_plain_text = {4{32'h7E47_0000 + 32'(k)}};
      tick();
      total++;
      if (strobes() !== exp_s) begin bad++; $display("FAIL basic_txt%0d_strobes got=%b exp=%b", k, strobes(), exp_s); end
      total++;
      if (o_counter_block !== {IV1, 32'(k)}) begin bad++; $display("FAIL basic_ctr%0d got=%h exp=%h", k, o_counter_block, {IV1, 32'(k)}); end
      total++;
      if (o_text_block !== {4{32'h7E47_0000 + 32'(k)}}) begin bad++; $display("FAIL basic_txt%0d got=%h", k, o_text_block); end
    end
    drive(1'b0, 3'b100, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'b0001_0000) begin bad++; $display("FAIL basic_len_strobes got=%b exp=%b", strobes(), 8'b0001_0000); end
    total++;
    if (o_len_block !== {64'h100, 64'h180}) begin bad++; $display("FAIL basic_len got=%h exp=%h", o_len_block, {64'h100, 64'h180}); end
    tick();
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL basic_after_strobes got=%b exp=0", strobes()); end
    total++;
    if (o_ghash_data !== {4{32'hAAD0_0001}} || o_counter_block !== {IV1, 32'd4}) begin
      bad++; $display("FAIL basic_hold got=%h/%h", o_ghash_data, o_counter_block);
    end
  endtask

  task automatic test_single_block();
    start(IV2, 64'h0, 64'h80);
    tick();
    total++;
    if (strobes() !== 8'b0010_0100 || o_j0_block !== {IV2, 32'h1}) begin
      bad++; $display("FAIL single_j0 got=%b %h", strobes(), o_j0_block);
    end
    drive(1'b0, 3'b111, 128'd0);
    i_plain_text = 128'h0BAD_F00D;
    tick();
    total++;
    if (strobes() !== 8'b1000_0111) begin bad++; $display("FAIL single_strobes got=%b exp=%b", strobes(), 8'b1000_0111); end
    total++;
    if (o_counter_block !== {IV2, 32'h2}) begin bad++; $display("FAIL single_ctr got=%h exp=%h", o_counter_block, {IV2, 32'h2}); end
    drive(1'b0, 3'b100, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'b0001_0000 || o_len_block !== {64'h0, 64'h80}) begin
      bad++; $display("FAIL single_len got=%b %h exp=%h", strobes(), o_len_block, {64'h0, 64'h80});
    end
  endtask

  task automatic test_start_err();
    start(IV3, 64'h100, 64'h0);
    tick();
    total++;
    if (strobes() !== 8'b0000_1000) begin bad++; $display("FAIL err_ptzero got=%b exp=%b", strobes(), 8'b0000_1000); end
    drive(1'b0, 3'b100, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL err_clear got=%b exp=0", strobes()); end
    start(IV3, 64'd100, 64'h80);
    tick();
    total++;
    if (strobes() !== 8'b0000_1000) begin bad++; $display("FAIL err_aad100 got=%b exp=%b", strobes(), 8'b0000_1000); end
    start(IV3, 64'h0, 64'd200);
    tick();
    total++;
    if (strobes() !== 8'b0000_1000) begin bad++; $display("FAIL err_pt200 got=%b exp=%b", strobes(), 8'b0000_1000); end
    drive(1'b0, 3'b000, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL err_stay_idle got=%b exp=0", strobes()); end
  endtask

  task automatic test_abort();
    start(IV3, 64'h0, 64'h200);
    tick();
    drive(1'b0, 3'b000, 128'd0);
    tick();
    drive(1'b0, 3'b001, 128'd1);
    tick();
    total++;
    if (strobes() !== 8'b1000_0100 || o_counter_block !== {IV3, 32'h3}) begin
      bad++; $display("FAIL abort_pre got=%b %h", strobes(), o_counter_block);
    end
    start(IV4, 64'h0, 64'h100);
    tick();
    total++;
    if (strobes() !== 8'b0010_1100) begin bad++; $display("FAIL abort_strobes got=%b exp=%b", strobes(), 8'b0010_1100); end
    total++;
    if (o_j0_block !== {IV4, 32'h1}) begin bad++; $display("FAIL abort_j0 got=%h exp=%h", o_j0_block, {IV4, 32'h1}); end
    drive(1'b0, 3'b000, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'b1000_0110 || o_counter_block !== {IV4, 32'h2}) begin
      bad++; $display("FAIL abort_restart got=%b %h exp=%h", strobes(), o_counter_block, {IV4, 32'h2});
    end
    drive(1'b0, 3'b011, 128'd1);
    tick();
    total++;
    if (strobes() !== 8'b1000_0101 || o_counter_block !== {IV4, 32'h3}) begin
      bad++; $display("FAIL abort_last got=%b %h", strobes(), o_counter_block);
    end
    drive(1'b0, 3'b100, 128'd0);
    tick();
    total++;
    if (strobes() !== 8'b0001_0000 || o_len_block !== {64'h0, 64'h100}) begin
      bad++; $display("FAIL abort_len got=%b %h", strobes(), o_len_block);
    end
  endtask

  task automatic test_wrap();
    start(IV5, 64'h0, 64'h100);
    tick();
    drive(1'b0, 3'b000, 128'hFFFF_FFFD);
    tick();
    total++;
    if (strobes() !== 8'b1000_0110 || o_counter_block !== {IV5, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL wrap_ff got=%b %h exp=%h", strobes(), o_counter_block, {IV5, 32'hFFFF_FFFF});
    end
    drive(1'b0, 3'b011, 128'hFFFF_FFFE);
    tick();
    total++;
    if (strobes() !== 8'b1000_0101 || o_counter_block !== {IV5, 32'h0}) begin
      bad++; $display("FAIL wrap_00 got=%b %h exp=%h", strobes(), o_counter_block, {IV5, 32'h0});
    end
    drive(1'b0, 3'b100, 128'd0);
    tick();
  endtask

  task automatic test_invalid_count();
    start(IV2, 64'h0, 64'h100);
    tick();
    drive(1'b0, 3'b000, 128'd0);
    tick();
    drive(1'b0, 3'b001, 128'd100000);
    tick();
    total++;
    if (strobes() !== 8'b0000_1000) begin bad++; $display("FAIL invalid_count got=%b exp=%b", strobes(), 8'b0000_1000); end
    drive(1'b0, 3'b011, 128'd1);
    tick();
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL invalid_idle got=%b exp=0", strobes()); end
  endtask

  task automatic test_reset_mid();
    start(IV1, 64'h100, 64'h80);
    i_pt_instance = 1'b1;
    tick();
    drive(1'b0, 3'b010, 128'd0);
    i_aad = 128'h1234;
    tick();
    total++;
    if (strobes() !== 8'b0100_0100 || o_pt_instance !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b pt=%b", strobes(), o_pt_instance);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (strobes() !== 8'h00) begin bad++; $display("FAIL midrst_strobes got=%b exp=0", strobes()); end
    total++;
    if ((|{o_counter_block, o_text_block, o_ghash_data, o_j0_block, o_len_block, o_pt_instance}) !== 1'b0) begin
      bad++; $display("FAIL midrst_data got=nonzero exp=0");
    end
    i_pt_instance = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ph;
      ph = (k == 0) ? 3'b010 : (k == 1) ? 3'b000 : (k == 2) ? 3'b111 : 3'b011;
      drive(1'b0, ph, 128'(k));
      tick();
      total++;
      if (strobes() !== 8'h00) begin bad++; $display("FAIL midrst_after%0d got=%b exp=0", k, strobes()); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_counter = '0; i_phase = 3'b100; i_plain_text = '0; i_aad = '0;
    i_iv = '0; i_instance_size = '0; i_new_instance = 1'b0; i_pt_instance = 1'b0;
    test_reset();
    test_basic();
    test_single_block();
    test_start_err();
    test_abort();
    test_wrap();
    test_invalid_count();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
